// File: rtl/tagged_regfile.sv
// Architectural register file with per-register busy bit and ROB tag for a renaming pipeline.
// Reads are combinational with commit-to-read bypass; issue, commit and flush act at the edge.
module tagged_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRP   = 4,
    parameter int unsigned NCP   = 2,
    parameter int unsigned NIP   = 2,
    parameter int unsigned TAGW  = 4,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   rd_addr   [NRP],
    output logic [XLEN-1:0] rd_data   [NRP],
    output logic            rd_busy   [NRP],
    output logic [TAGW-1:0] rd_tag    [NRP],

    input  logic            iss_valid [NIP],
    input  logic [AW-1:0]   iss_rd    [NIP],
    input  logic [TAGW-1:0] iss_tag   [NIP],

    input  logic            cm_valid  [NCP],
    input  logic [AW-1:0]   cm_rd     [NCP],
    input  logic [TAGW-1:0] cm_tag    [NCP],
    input  logic [XLEN-1:0] cm_data   [NCP],

    input  logic            flush
);

    logic [XLEN-1:0] data_q [NREGS];
    logic [XLEN-1:0] data_d [NREGS];
    logic            busy_q [NREGS];
    logic            busy_d [NREGS];
    logic [TAGW-1:0] tag_q  [NREGS];
    logic [TAGW-1:0] tag_d  [NREGS];

    // Commits and issues to x0 are dropped here, so x0 storage stays zero.
    logic cm_en  [NCP];
    logic iss_en [NIP];

    always_comb begin
        for (int unsigned c = 0; c < NCP; c++) begin
            cm_en[c] = cm_valid[c] && (cm_rd[c] != '0);
        end
        for (int unsigned i = 0; i < NIP; i++) begin
            iss_en[i] = iss_valid[i] && (iss_rd[i] != '0);
        end
    end

    // Read ports: later commit ports override earlier ones in the bypass; issues are not visible.
    always_comb begin
        for (int unsigned p = 0; p < NRP; p++) begin
            rd_data[p] = data_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            rd_tag[p]  = tag_q[rd_addr[p]];
            for (int unsigned c = 0; c < NCP; c++) begin
                if (cm_en[c] && (cm_rd[c] == rd_addr[p])) begin
                    rd_data[p] = cm_data[c];
                    if (cm_tag[c] == tag_q[rd_addr[p]]) begin
                        rd_busy[p] = 1'b0;
                    end
                end
            end
        end
    end

    // Next state: commits first, then flush or issues, so an issue wins busy/tag over a commit.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int unsigned c = 0; c < NCP; c++) begin
            if (cm_en[c]) begin
                data_d[cm_rd[c]] = cm_data[c];
                if (busy_q[cm_rd[c]] && (tag_q[cm_rd[c]] == cm_tag[c])) begin
                    busy_d[cm_rd[c]] = 1'b0;
                end
            end
        end
        if (flush) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                busy_d[r] = 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NIP; i++) begin
                if (iss_en[i]) begin
                    busy_d[iss_rd[i]] = 1'b1;
                    tag_d[iss_rd[i]]  = iss_tag[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_tagged_regfile.sv
// Randomized self-checking bench for tagged_regfile against an array-based reference model.
module tb_tagged_regfile;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRP = 4;
    localparam int NCP = 2;
    localparam int NIP = 2;
    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      rd_addr   [NRP];
    logic [XLEN-1:0] rd_data   [NRP];
    logic            rd_busy   [NRP];
    logic [TAGW-1:0] rd_tag    [NRP];
    logic            iss_valid [NIP];
    logic [4:0]      iss_rd    [NIP];
    logic [TAGW-1:0] iss_tag   [NIP];
    logic            cm_valid  [NCP];
    logic [4:0]      cm_rd     [NCP];
    logic [TAGW-1:0] cm_tag    [NCP];
    logic [XLEN-1:0] cm_data   [NCP];
    logic            flush;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] m_data [NREGS];
    logic            m_busy [NREGS];
    logic [TAGW-1:0] m_tag  [NREGS];

    tagged_regfile #(
        .XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NCP(NCP), .NIP(NIP), .TAGW(TAGW)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    // Expected combinational read values from the model plus the current commit inputs.
    function automatic logic [XLEN-1:0] m_rdata(input logic [4:0] a);
        logic [XLEN-1:0] r = m_data[a];
        for (int c = 0; c < NCP; c++)
            if (cm_valid[c] && cm_rd[c] == a) r = cm_data[c];
        return (a == 5'd0) ? '0 : r;
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        logic b = m_busy[a];
        for (int c = 0; c < NCP; c++)
            if (cm_valid[c] && cm_rd[c] == a && cm_tag[c] == m_tag[a]) b = 1'b0;
        return (a == 5'd0) ? 1'b0 : b;
    endfunction

    task automatic m_edge();
        logic [XLEN-1:0] nd [NREGS];
        logic            nb [NREGS];
        logic [TAGW-1:0] nt [NREGS];
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
            return;
        end
        nd = m_data; nb = m_busy; nt = m_tag;
        for (int c = 0; c < NCP; c++) begin
            if (cm_valid[c] && cm_rd[c] != 5'd0) begin
                nd[cm_rd[c]] = cm_data[c];
                if (m_busy[cm_rd[c]] && m_tag[cm_rd[c]] == cm_tag[c]) nb[cm_rd[c]] = 1'b0;
            end
        end
        for (int i = 0; i < NIP; i++) begin
            if (!flush && iss_valid[i] && iss_rd[i] != 5'd0) begin
                nb[iss_rd[i]] = 1'b1;
                nt[iss_rd[i]] = iss_tag[i];
            end
        end
        if (flush) for (int r = 0; r < NREGS; r++) nb[r] = 1'b0;
        m_data = nd; m_busy = nb; m_tag = nt;
    endtask

    task automatic idle();
        reset = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < NIP; i++) begin
            iss_valid[i] = 1'b0; iss_rd[i] = '0; iss_tag[i] = '0;
        end
        for (int c = 0; c < NCP; c++) begin
            cm_valid[c] = 1'b0; cm_rd[c] = '0; cm_tag[c] = '0; cm_data[c] = '0;
        end
        for (int p = 0; p < NRP; p++) rd_addr[p] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        for (int c = 0; c < NCP; c++) begin
            cm_valid[c] = 1'b1; cm_rd[c] = 5'(c + 3); cm_data[c] = $urandom; cm_tag[c] = '0;
        end
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd6; iss_tag[0] = 4'd5;
        flush = 1'b1;
        tick();
        idle();
        for (int g = 0; g < NREGS / NRP; g++) begin
            for (int p = 0; p < NRP; p++) rd_addr[p] = 5'(g * NRP + p);
            #1;
            for (int p = 0; p < NRP; p++) begin
                tests++;
                if (rd_data[p] !== '0 || rd_busy[p] !== 1'b0 || rd_tag[p] !== '0) begin
                    fails++;
                    $display("FAIL reset x%0d: got data=%h busy=%b tag=%0d, want 0/0/0",
                             rd_addr[p], rd_data[p], rd_busy[p], rd_tag[p]);
                end
            end
        end
    endtask

    task automatic test_issue_commit();
        idle();
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd5; iss_tag[0] = 4'd3;
        tick();
        idle();
        rd_addr[0] = 5'd5;
        #1;
        tests++;
        if (rd_busy[0] !== 1'b1 || rd_tag[0] !== 4'd3) begin
            fails++;
            $display("FAIL issue x5: got busy=%b tag=%0d, want 1/3", rd_busy[0], rd_tag[0]);
        end
        cm_valid[0] = 1'b1; cm_rd[0] = 5'd5; cm_tag[0] = 4'd3; cm_data[0] = 32'hDEADBEEF;
        #1;
        tests++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL bypass x5: got data=%h busy=%b, want deadbeef/0", rd_data[0], rd_busy[0]);
        end
        tick();
        idle();
        rd_addr[0] = 5'd5;
        #1;
        tests++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL commit x5: got data=%h busy=%b, want deadbeef/0", rd_data[0], rd_busy[0]);
        end
    endtask

    task automatic test_stale_tag();
        idle();
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd7; iss_tag[0] = 4'd1;
        tick();
        iss_tag[0] = 4'd2;
        tick();
        idle();
        cm_valid[0] = 1'b1; cm_rd[0] = 5'd7; cm_tag[0] = 4'd1; cm_data[0] = 32'h11;
        rd_addr[1] = 5'd7;
        #1;
        tests++;
        if (rd_busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL stale bypass busy x7: got %b, want 1", rd_busy[1]);
        end
        tick();
        idle();
        rd_addr[1] = 5'd7;
        #1;
        tests++;
        if (rd_data[1] !== 32'h11 || rd_busy[1] !== 1'b1 || rd_tag[1] !== 4'd2) begin
            fails++;
            $display("FAIL stale tag x7: got data=%h busy=%b tag=%0d, want 11/1/2",
                     rd_data[1], rd_busy[1], rd_tag[1]);
        end
    endtask

    task automatic test_multi_port();
        idle();
        cm_valid[0] = 1'b1; cm_rd[0] = 5'd9; cm_data[0] = 32'hA; cm_tag[0] = 4'd15;
        cm_valid[1] = 1'b1; cm_rd[1] = 5'd9; cm_data[1] = 32'hB; cm_tag[1] = 4'd15;
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd4; iss_tag[0] = 4'd6;
        iss_valid[1] = 1'b1; iss_rd[1] = 5'd4; iss_tag[1] = 4'd9;
        rd_addr[2] = 5'd9; rd_addr[3] = 5'd4;
        #1;
        tests++;
        if (rd_data[2] !== 32'hB || rd_busy[3] !== 1'b0) begin
            fails++;
            $display("FAIL multi bypass: got x9=%h x4busy=%b, want b/0", rd_data[2], rd_busy[3]);
        end
        tick();
        idle();
        rd_addr[2] = 5'd9; rd_addr[3] = 5'd4;
        #1;
        tests++;
        if (rd_data[2] !== 32'hB || rd_busy[3] !== 1'b1 || rd_tag[3] !== 4'd9) begin
            fails++;
            $display("FAIL multi port: got x9=%h x4 busy=%b tag=%0d, want b/1/9",
                     rd_data[2], rd_busy[3], rd_tag[3]);
        end
    endtask

    task automatic test_x0();
        idle();
        cm_valid[0] = 1'b1; cm_rd[0] = 5'd0; cm_data[0] = 32'hFFFF;
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd0; iss_tag[0] = 4'd5;
        rd_addr[0] = 5'd0;
        #1;
        tests++;
        if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL x0 bypass: got data=%h busy=%b, want 0/0", rd_data[0], rd_busy[0]);
        end
        tick();
        idle();
        #1;
        tests++;
        if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0 || rd_tag[0] !== '0) begin
            fails++;
            $display("FAIL x0 stored: got data=%h busy=%b tag=%0d, want 0/0/0",
                     rd_data[0], rd_busy[0], rd_tag[0]);
        end
    endtask

    task automatic test_flush();
        idle();
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd1; iss_tag[0] = 4'd1;
        iss_valid[1] = 1'b1; iss_rd[1] = 5'd2; iss_tag[1] = 4'd2;
        tick();
        idle();
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd3; iss_tag[0] = 4'd3;
        tick();
        idle();
        flush = 1'b1;
        iss_valid[0] = 1'b1; iss_rd[0] = 5'd8; iss_tag[0] = 4'd7;
        cm_valid[0] = 1'b1; cm_rd[0] = 5'd3; cm_tag[0] = 4'd0; cm_data[0] = 32'h55;
        tick();
        idle();
        rd_addr[0] = 5'd1; rd_addr[1] = 5'd2; rd_addr[2] = 5'd3; rd_addr[3] = 5'd8;
        #1;
        for (int p = 0; p < NRP; p++) begin
            tests++;
            if (rd_busy[p] !== 1'b0) begin
                fails++;
                $display("FAIL flush busy x%0d: got %b, want 0", rd_addr[p], rd_busy[p]);
            end
        end
        tests++;
        if (rd_data[2] !== 32'h55 || rd_tag[2] !== 4'd3 || rd_tag[0] !== 4'd1) begin
            fails++;
            $display("FAIL flush data/tag: got x3=%h tag3=%0d tag1=%0d, want 55/3/1",
                     rd_data[2], rd_tag[2], rd_tag[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            idle();
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NIP; i++) begin
                iss_valid[i] = 1'($urandom_range(0, 1));
                iss_rd[i]    = 5'($urandom_range(0, 7));
                iss_tag[i]   = 4'($urandom_range(0, 3));
            end
            for (int c = 0; c < NCP; c++) begin
                cm_valid[c] = 1'($urandom_range(0, 1));
                cm_rd[c]    = 5'($urandom_range(0, 7));
                cm_tag[c]   = 4'($urandom_range(0, 3));
                cm_data[c]  = $urandom;
            end
            for (int p = 0; p < NRP; p++) rd_addr[p] = 5'($urandom_range(0, 9));
            #1;
            for (int p = 0; p < NRP; p++) begin
                tests++;
                if (rd_data[p] !== m_rdata(rd_addr[p]) || rd_busy[p] !== m_rbusy(rd_addr[p]) ||
                    rd_tag[p] !== m_tag[rd_addr[p]]) begin
                    fails++;
                    $display("FAIL random cyc%0d port%0d x%0d: got %h/%b/%0d, want %h/%b/%0d",
                             n, p, rd_addr[p], rd_data[p], rd_busy[p], rd_tag[p],
                             m_rdata(rd_addr[p]), m_rbusy(rd_addr[p]), m_tag[rd_addr[p]]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        idle();
        reset = 1'b1;
        tick();
        tick();
        test_reset();
        test_issue_commit();
        test_stale_tag();
        test_multi_port();
        test_x0();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tagged_regfile.md
TAGGED_REGFILE -- requirements
Module: tagged_regfile

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width.
REQ-002 SHALL provide parameter NREGS, default 32, architectural register count (power of two); AW = log2(NREGS).
REQ-003 SHALL provide parameter NRP, default 4, read-port count.
REQ-004 SHALL provide parameter NCP, default 2, commit (write) port count.
REQ-005 SHALL provide parameter NIP, default 2, issue (tag-allocate) port count.
REQ-006 SHALL provide parameter TAGW, default 4, ROB tag width.
REQ-007 SHALL use one clock; reset is synchronous and active-high.
REQ-008 SHALL have ports:
- clk, input, 1, sole clock.
- reset, input, 1, synchronous active-high reset.
- rd_addr[NRP], input, AW each, read register.
- rd_data[NRP], output, XLEN each, read value.
- rd_busy[NRP], output, 1 each, register awaits an in-flight producer.
- rd_tag[NRP], output, TAGW each, ROB tag of the pending producer.
- iss_valid[NIP], input, 1 each, issue allocates a destination.
- iss_rd[NIP], input, AW each, issue destination register.
- iss_tag[NIP], input, TAGW each, ROB tag of the issuing instruction.
- cm_valid[NCP], input, 1 each, commit writes back.
- cm_rd[NCP], input, AW each, commit destination register.
- cm_tag[NCP], input, TAGW each, ROB tag of the committing instruction.
- cm_data[NCP], input, XLEN each, commit write data.
- flush, input, 1, pipeline squash.

Function
REQ-009 SHALL hold per register: data (XLEN), busy (1), tag (TAGW).
REQ-010 SHALL tie register 0 to data 0 and busy 0; issues and commits to register 0 are ignored.
REQ-011 SHALL make reads combinational, with zero latency.
REQ-012 SHALL make rd_data equal cm_data of the highest-index valid commit port whose cm_rd matches rd_addr; with no match, rd_data equals the stored data (write-to-read bypass).
REQ-013 SHALL make rd_busy equal stored busy AND NOT (a same-cycle valid commit matches the address with cm_tag equal to the stored tag); rd_tag equals the stored tag.
REQ-014 SHALL NOT let same-cycle issues affect read outputs; the external rename logic resolves intra-group dependencies.
REQ-015 SHALL, on a valid commit, write cm_data to cm_rd at the clock edge.
REQ-016 SHALL, on a valid commit, clear busy only if busy is set and the stored tag equals cm_tag.
REQ-017 SHALL, on a valid issue, set busy and load iss_tag into iss_rd at the clock edge.
REQ-018 SHALL, when several commit ports target one register, apply data from the highest-index port; each port independently evaluates its tag-match clear.
REQ-019 SHALL, when several issue ports target one register, apply the highest-index port's tag.
REQ-020 SHALL, when an issue and a commit hit the same register in one cycle, write the data, leave busy set, and store the tag from the issue.
REQ-021 SHALL, on flush, clear every busy bit at the edge, ignore same-cycle issues, and still perform same-cycle commit data writes.
REQ-022 SHALL leave tag values unchanged by flush.

Reset
REQ-023 SHALL, on reset, clear all data, busy, and tag bits at the edge; reset overrides flush, issue, and commit.
REQ-024 SHALL, in the cycle after reset with no commits, drive all rd_data, rd_busy, and rd_tag to 0.

Verification
REQ-025 Reset, then read all registers -> rd_data=0, rd_busy=0, rd_tag=0.
REQ-026 Issue rd=5 tag=3; next cycle read x5 -> busy=1, tag=3; commit rd=5 tag=3 data=0xDEADBEEF; same cycle read x5 -> data=0xDEADBEEF, busy=0; next cycle stored busy=0.
REQ-027 Issue x7 tag=1, then issue x7 tag=2, then commit x7 tag=1 data=0x11 -> data=0x11, busy stays 1, tag=2.
REQ-028 Same cycle: commit port0 x9=0xA and port1 x9=0xB, and issue port0 x4 tag=6 with port1 x4 tag=9 -> x9=0xB, x4 tag=9 and busy.
REQ-029 Commit x0=0xFFFF and issue x0 -> x0 reads 0, not busy.
REQ-030 Three registers busy; flush with a same-cycle issue x8 and commit x3=0x55 -> all busy=0, x8 not busy, x3=0x55.
